// File: rtl/priority_req_latch_v.sv
// priority_req_latch_v
// Request-capture stage in front of the 4-to-2 priority encoder. Rising edges
// on the request lines become sticky pending bits that stay set until the
// consumer acks them. The masked pending vector feeds the encoder directly.
//
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_req[3:0]          synchronous request lines (bit 3 = top priority)
//   i_en_wr, i_en_data  enable register write strobe / value
//   i_ack, i_ack_idx    one-cycle ack strobe and line index to clear
//   i_ovf_clr           clears all overflow flags
//   o_pend[3:0]         pend & en, to encoder i_code
//   o_irq               |o_pend
//   o_ovf[3:0]          sticky per-line overflow
//   o_evt_cnt[7:0]      saturating accepted-event count

// Per-line slice: edge detect, sticky pending bit, sticky overflow flag.
module priority_req_latch_v_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack_hit,
  input  logic ovf_clr,
  output logic pend,
  output logic ovf,
  output logic accept
);
  logic req_q;
  logic rise;
  logic ovf_set;

  assign rise    = req & ~req_q;
  // A rise on a line being acked this cycle replaces the old event rather
  // than colliding with it, so it is accepted and never overflows.
  assign accept  = rise & (~pend | ack_hit);
  assign ovf_set = rise & pend & ~ack_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;
      pend  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      req_q <= req;
      if (rise)         pend <= 1'b1;   // set beats clear
      else if (ack_hit) pend <= 1'b0;
      if (ovf_set)      ovf  <= 1'b1;   // new overflow beats clear
      else if (ovf_clr) ovf  <= 1'b0;
    end
  end
endmodule

module priority_req_latch_v (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  input  logic       i_en_wr,
  input  logic [3:0] i_en_data,
  input  logic       i_ack,
  input  logic [1:0] i_ack_idx,
  input  logic       i_ovf_clr,
  output logic [3:0] o_pend,
  output logic       o_irq,
  output logic [3:0] o_ovf,
  output logic [7:0] o_evt_cnt
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] pend;
  logic [NUM_LANES-1:0] accept;
  logic [NUM_LANES-1:0] en;
  logic [2:0]           inc;
  logic [8:0]           sum;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    priority_req_latch_v_lane u_lane (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .req     (i_req[g]),
      .ack_hit (i_ack && (i_ack_idx == 2'(g))),
      .ovf_clr (i_ovf_clr),
      .pend    (pend[g]),
      .ovf     (o_ovf[g]),
      .accept  (accept[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) en <= 4'hF;
    else if (i_en_wr) en <= i_en_data;
  end

  // Outputs decode from flops only; no input reaches them combinationally.
  assign o_pend = pend & en;
  assign o_irq  = |o_pend;

  always_comb begin
    inc = 3'd0;
    for (int i = 0; i < NUM_LANES; i++) inc = inc + {2'b00, accept[i]};
  end

  // 9-bit sum so a carry out of bit 7 pins the count at 255 instead of wrapping.
  assign sum = {1'b0, o_evt_cnt} + {6'b0, inc};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_evt_cnt <= 8'd0;
    else          o_evt_cnt <= sum[8] ? 8'hFF : sum[7:0];
  end
endmodule

// File: tb/tb_priority_req_latch_v.sv
module tb_priority_req_latch_v;
  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [3:0] i_req;
  logic       i_en_wr;
  logic [3:0] i_en_data;
  logic       i_ack;
  logic [1:0] i_ack_idx;
  logic       i_ovf_clr;
  logic [3:0] o_pend;
  logic       o_irq;
  logic [3:0] o_ovf;
  logic [7:0] o_evt_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model state, one entry per line.
  bit m_prev [4];
  bit m_pend [4];
  bit m_en   [4];
  bit m_ovf  [4];
  int m_cnt;

  priority_req_latch_v dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_en_wr(i_en_wr),
    .i_en_data(i_en_data), .i_ack(i_ack), .i_ack_idx(i_ack_idx),
    .i_ovf_clr(i_ovf_clr), .o_pend(o_pend), .o_irq(o_irq), .o_ovf(o_ovf),
    .o_evt_cnt(o_evt_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      m_prev[n] = 0; m_pend[n] = 0; m_en[n] = 1; m_ovf[n] = 0;
    end
    m_cnt = 0;
  endtask

  function automatic logic [3:0] pack(input bit a [4]);
    logic [3:0] v;
    for (int n = 0; n < 4; n++) v[n] = a[n];
    return v;
  endfunction

  task automatic check_model(input string tag);
    logic [3:0] ep;
    for (int n = 0; n < 4; n++) ep[n] = m_pend[n] & m_en[n];
    chk({tag, ".pend"}, {4'h0, o_pend}, {4'h0, ep});
    chk({tag, ".irq"},  {7'h0, o_irq},  {7'h0, (ep != 4'h0)});
    chk({tag, ".ovf"},  {4'h0, o_ovf},  {4'h0, pack(m_ovf)});
    chk({tag, ".cnt"},  o_evt_cnt,      m_cnt[7:0]);
  endtask

  // Apply one cycle of inputs, advance model by the specification's rules,
  // then compare just after the edge.
  task automatic step(input string tag, input logic [3:0] req, input logic en_wr,
                      input logic [3:0] en_data, input logic ack,
                      input logic [1:0] idx, input logic ovf_clr);
    int events;
    i_req = req; i_en_wr = en_wr; i_en_data = en_data;
    i_ack = ack; i_ack_idx = idx; i_ovf_clr = ovf_clr;
    @(posedge i_clk);
    events = 0;
    for (int n = 0; n < 4; n++) begin
      bit r, a;
      r = req[n] && !m_prev[n];
      a = ack && (int'(idx) == n);
      if (r && (!m_pend[n] || a)) events++;
      if (r && m_pend[n] && !a) m_ovf[n] = 1;
      else if (ovf_clr)         m_ovf[n] = 0;
      if (r)      m_pend[n] = 1;
      else if (a) m_pend[n] = 0;
      if (en_wr)  m_en[n] = en_data[n];
      m_prev[n] = req[n];
    end
    m_cnt = (m_cnt + events > 255) ? 255 : m_cnt + events;
    #1;
    check_model(tag);
  endtask

  initial begin
    i_rst_n = 1'b0; i_req = '0; i_en_wr = 0; i_en_data = '0;
    i_ack = 0; i_ack_idx = '0; i_ovf_clr = 0;
    model_reset();
    #12;
    check_model("reset");
    i_rst_n = 1'b1;

    // Single pulse on line 2, then ack it.
    step("pulse2", 4'b0100, 0, 4'h0, 0, 2'd0, 0);
    chk("pulse2.lit_pend", {4'h0, o_pend}, 8'h04);
    chk("pulse2.lit_cnt", o_evt_cnt, 8'd1);
    step("ack2", 4'b0000, 0, 4'h0, 1, 2'd2, 0);
    chk("ack2.lit_irq", {7'h0, o_irq}, 8'h00);

    // All four at once, then ack 3,2,1,0 with requests held high.
    step("all4", 4'b1111, 0, 4'h0, 0, 2'd0, 0);
    chk("all4.lit_cnt", o_evt_cnt, 8'd5);
    step("ack3", 4'b1111, 0, 4'h0, 1, 2'd3, 0);
    chk("ack3.lit", {4'h0, o_pend}, 8'h07);
    step("ack2b", 4'b1111, 0, 4'h0, 1, 2'd2, 0);
    step("ack1", 4'b1111, 0, 4'h0, 1, 2'd1, 0);
    step("ack0", 4'b1111, 0, 4'h0, 1, 2'd0, 0);
    chk("ack0.lit", {4'h0, o_pend}, 8'h00);
    step("ack0.again", 4'b0000, 0, 4'h0, 1, 2'd0, 0);

    // Overflow on line 0, clear, then rise coinciding with ack.
    step("ovf.rise1", 4'b0001, 0, 4'h0, 0, 2'd0, 0);
    step("ovf.low",   4'b0000, 0, 4'h0, 0, 2'd0, 0);
    step("ovf.rise2", 4'b0001, 0, 4'h0, 0, 2'd0, 0);
    chk("ovf.lit", {4'h0, o_ovf}, 8'h01);
    chk("ovf.cnt_hold", o_evt_cnt, 8'd6);
    step("ovf.clr",   4'b0000, 0, 4'h0, 0, 2'd0, 1);
    step("ovf.idle",  4'b0000, 0, 4'h0, 0, 2'd0, 0);
    step("ovf.ackrise", 4'b0001, 0, 4'h0, 1, 2'd0, 0);
    chk("ackrise.lit_pend", {4'h0, o_pend}, 8'h01);
    chk("ackrise.lit_cnt", o_evt_cnt, 8'd7);
    step("ovf.drain", 4'b0000, 0, 4'h0, 1, 2'd0, 0);

    // Masked line latches while disabled, appears once re-enabled.
    step("en.off",  4'b0000, 1, 4'b0000, 0, 2'd0, 0);
    step("en.rise3", 4'b1000, 0, 4'h0, 0, 2'd0, 0);
    chk("en.masked", {4'h0, o_pend}, 8'h00);
    step("en.on3",  4'b0000, 1, 4'b1000, 0, 2'd0, 0);
    chk("en.exposed", {4'h0, o_pend}, 8'h08);
    step("en.ack3", 4'b0000, 0, 4'h0, 1, 2'd3, 0);
    step("en.all",  4'b0000, 1, 4'hF, 0, 2'd0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step("rand", 4'($urandom), ($urandom_range(7) == 0), 4'($urandom),
           $urandom_range(1) == 1, 2'($urandom), ($urandom_range(7) == 0));
    end

    // Saturation: re-enable everything, clear state via reset, 300 events.
    i_rst_n = 1'b0; model_reset(); #2; i_rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step("sat.rise", 4'b0001, 0, 4'h0, 1, 2'd0, 0);
      step("sat.low",  4'b0000, 0, 4'h0, 0, 2'd0, 0);
    end
    chk("sat.lit255", o_evt_cnt, 8'd255);
    step("sat.burst", 4'b1111, 0, 4'h0, 0, 2'd0, 0);
    chk("sat.burst.lit", o_evt_cnt, 8'd255);
    step("sat.low2", 4'b0000, 0, 4'h0, 0, 2'd0, 0);

    // Asynchronous reset mid-cycle with 4'b1010 pending.
    step("ar.ack0", 4'b0000, 0, 4'h0, 1, 2'd0, 0);
    step("ar.ack1", 4'b0000, 0, 4'h0, 1, 2'd1, 0);
    step("ar.ack2", 4'b0000, 0, 4'h0, 1, 2'd2, 0);
    step("ar.ack3", 4'b0000, 0, 4'h0, 1, 2'd3, 0);
    step("ar.set",  4'b1010, 0, 4'h0, 0, 2'd0, 0);
    chk("ar.pre", {4'h0, o_pend}, 8'h0A);
    #2;
    i_req = 4'b0001; i_ack = 0; i_ovf_clr = 0; i_en_wr = 0;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    check_model("ar.async");
    chk("ar.lit_pend", {4'h0, o_pend}, 8'h00);
    #2;
    i_rst_n = 1'b1;
    step("ar.first", 4'b0001, 0, 4'h0, 0, 2'd0, 0);
    chk("ar.first.lit", o_evt_cnt, 8'd1);
    step("ar.held", 4'b0001, 0, 4'h0, 0, 2'd0, 0);
    chk("ar.held.lit", o_evt_cnt, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
